// File: rtl/dma_read_engine.sv
// dma_read_engine: AXI4 read side of the DMA.
// Takes a start command (byte address + byte count), splits the transfer
// into INCR bursts of at most MAX_BURST beats that never cross a 4 KB page,
// and streams every returned word straight into the transfer FIFO.
// One burst is outstanding at a time; read_done pulses after the last push.
module dma_read_engine #(
    parameter int ADDR_W    = 32,
    parameter int MAX_BURST = 16,
    parameter int AXI_ID    = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_read,
    input  logic [15:0]       r_size_data,
    input  logic [31:0]       raddr_reg,
    output logic              read_done,
    output logic              rd_err,
    output logic [3:0]        arid,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic              arvalid,
    input  logic              arready,
    input  logic [31:0]       rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,
    output logic [31:0]       fifo_wdata,
    output logic              fifo_wen,
    input  logic              fifo_full
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;        // start address of the next burst
    logic [13:0]       words_rem;   // words still to be pushed
    logic [4:0]        beat_cnt;    // beats left in the current burst

    logic [ADDR_W-1:0] start_addr;
    logic [13:0]       start_words;
    logic [ADDR_W-1:0] burst_bytes;
    logic              last_beat;
    logic              beat_err;
    logic              unused_bits;

    // Burst length: limited by MAX_BURST, the remaining words and the
    // distance to the next 4 KB page boundary (offs is word aligned).
    function automatic logic [7:0] calc_arlen(input logic [11:0] offs,
                                              input logic [13:0] w);
        logic [13:0] room;
        logic [13:0] beats;
        room  = (14'd4096 - {2'b00, offs}) >> 2;
        beats = 14'(MAX_BURST);
        if (w < beats)    beats = w;
        if (room < beats) beats = room;
        return 8'(beats - 14'd1);
    endfunction

    assign start_addr  = ADDR_W'({raddr_reg[31:2], 2'b00});
    assign start_words = r_size_data[15:2];
    assign burst_bytes = ADDR_W'({arlen, 2'b00}) + ADDR_W'(4);
    assign last_beat   = (beat_cnt == 5'd1);
    // A beat is in error on a non-OKAY response or an rlast that disagrees
    // with our own beat count.
    assign beat_err    = (rresp != 2'b00) || (rlast != last_beat);

    // Byte-offset bits of the command are intentionally dropped.
    assign unused_bits = ^{r_size_data[1:0], raddr_reg[1:0]};

    assign arid    = 4'(AXI_ID);
    assign arsize  = 3'b010;
    assign arburst = 2'b01;

    // The FIFO push path is combinational so a beat lands the cycle it arrives.
    assign rready     = (state == DATA) && !fifo_full;
    assign fifo_wen   = rvalid && rready;
    assign fifo_wdata = rdata;

    // Transfer sequencing: command latch, AR issue, beat counting, completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            words_rem <= '0;
            beat_cnt  <= '0;
            araddr    <= '0;
            arlen     <= '0;
            arvalid   <= 1'b0;
            read_done <= 1'b0;
            rd_err    <= 1'b0;
        end else begin
            read_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_read) begin
                        addr      <= start_addr;
                        words_rem <= start_words;
                        rd_err    <= 1'b0;
                        if (start_words == 14'd0) begin
                            state <= DONE;
                        end else begin
                            araddr  <= start_addr;
                            arlen   <= calc_arlen(start_addr[11:0], start_words);
                            arvalid <= 1'b1;
                            state   <= ADDR;
                        end
                    end
                end
                ADDR: begin
                    if (arready) begin
                        arvalid  <= 1'b0;
                        addr     <= addr + burst_bytes;
                        beat_cnt <= 5'(arlen) + 5'd1;
                        state    <= DATA;
                    end
                end
                DATA: begin
                    if (fifo_wen) begin
                        beat_cnt  <= beat_cnt - 5'd1;
                        words_rem <= words_rem - 14'd1;
                        if (beat_err) begin
                            rd_err <= 1'b1;
                        end
                        if (last_beat) begin
                            if (words_rem != 14'd1) begin
                                araddr  <= addr;
                                arlen   <= calc_arlen(addr[11:0], words_rem - 14'd1);
                                arvalid <= 1'b1;
                                state   <= ADDR;
                            end else begin
                                state <= DONE;
                            end
                        end
                    end
                end
                DONE: begin
                    read_done <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_read_engine.sv
// Testbench for dma_read_engine: AXI slave model plus a scoreboard of
// expected AR commands and expected FIFO words.
module tb_dma_read_engine;

    logic        clk;
    logic        rst_n;
    logic        start_read;
    logic [15:0] r_size_data;
    logic [31:0] raddr_reg;
    logic        read_done;
    logic        rd_err;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [31:0] fifo_wdata;
    logic        fifo_wen;
    logic        fifo_full;

    dma_read_engine #(.ADDR_W(32), .MAX_BURST(16), .AXI_ID(0)) dut (
        .clk(clk), .rst_n(rst_n), .start_read(start_read),
        .r_size_data(r_size_data), .raddr_reg(raddr_reg),
        .read_done(read_done), .rd_err(rd_err), .arid(arid),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready), .rdata(rdata), .rresp(rresp),
        .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .fifo_wdata(fifo_wdata), .fifo_wen(fifo_wen), .fifo_full(fifo_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard
    logic [31:0] exp_q[$];
    logic [39:0] exp_ar[$];
    int push_cnt, first_push_cyc, last_push_cyc, done_cnt;

    // Slave model state
    int          ar_delay = 0;
    int          err_beat = -1;
    int          glob_beat = 0;
    bit          pend;
    logic [31:0] cur_addr;
    int          beats_left;
    int          arv_cycles;
    logic        sl_ar_hs, sl_r_hs;
    logic [31:0] sl_la;
    logic [7:0]  sl_ll;

    // Monitor state
    logic        ar_pend_prev = 1'b0;
    logic [31:0] prev_a;
    logic [7:0]  prev_l;
    logic [39:0] e_ar;
    logic [31:0] e_w;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[15:0]};
    endfunction

    // AXI read slave: data is a function of the beat address.
    initial begin
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0;
        pend = 1'b0; beats_left = 0; arv_cycles = 0; cur_addr = '0;
        forever begin
            @(negedge clk);
            sl_ar_hs = arvalid && arready;
            sl_r_hs  = rvalid && rready;
            sl_la    = araddr;
            sl_ll    = arlen;
            if (arvalid && !arready) arv_cycles++;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                pend = 1'b0; beats_left = 0; arv_cycles = 0;
                arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
            end else begin
                if (sl_r_hs) begin
                    cur_addr = cur_addr + 32'd4;
                    beats_left--;
                    glob_beat++;
                end
                if (beats_left == 0) pend = 1'b0;
                if (sl_ar_hs) begin
                    pend = 1'b1;
                    cur_addr = sl_la;
                    beats_left = int'(sl_ll) + 1;
                    arv_cycles = 0;
                end
                arready = arvalid && !pend && (arv_cycles >= ar_delay);
                if (pend) begin
                    rvalid = 1'b1;
                    rdata  = data_of(cur_addr);
                    rresp  = (glob_beat == err_beat) ? 2'b10 : 2'b00;
                    rlast  = (beats_left == 1);
                end else begin
                    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
                end
            end
        end
    end

    // Monitor: AR commands, AR stability, FIFO pushes against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (ar_pend_prev) begin
                    total++;
                    if (!arvalid || araddr !== prev_a || arlen !== prev_l) begin
                        bad++;
                        $display("FAIL ar_stable: arvalid=%b araddr=%h arlen=%0d required 1 %h %0d",
                                 arvalid, araddr, arlen, prev_a, prev_l);
                    end
                end
                ar_pend_prev = arvalid && !arready;
                prev_a = araddr;
                prev_l = arlen;
                if (arvalid && arready) begin
                    total++;
                    if (exp_ar.size() == 0) begin
                        bad++;
                        $display("FAIL ar_unexpected: araddr=%h arlen=%0d required none", araddr, arlen);
                    end else begin
                        e_ar = exp_ar.pop_front();
                        if ({araddr, arlen} !== e_ar) begin
                            bad++;
                            $display("FAIL ar_cmd: araddr=%h arlen=%0d required %h %0d",
                                     araddr, arlen, e_ar[39:8], e_ar[7:0]);
                        end
                    end
                end
                if (fifo_wen) begin
                    total++;
                    if (fifo_full !== 1'b0) begin
                        bad++;
                        $display("FAIL push_while_full: fifo_full=%b required 0", fifo_full);
                    end
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL push_unexpected: data=%h required none", fifo_wdata);
                    end else begin
                        e_w = exp_q.pop_front();
                        if (fifo_wdata !== e_w) begin
                            bad++;
                            $display("FAIL push_data: got %h required %h", fifo_wdata, e_w);
                        end
                    end
                    if (push_cnt == 0) first_push_cyc = cyc;
                    last_push_cyc = cyc;
                    push_cnt++;
                end
                if (read_done) done_cnt++;
            end else begin
                ar_pend_prev = 1'b0;
            end
        end
    end

    task automatic clear_sb;
        push_cnt = 0; done_cnt = 0; first_push_cyc = -1; last_push_cyc = -1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [15:0] sz, input bit expect_data);
        int nw;
        nw = int'(sz[15:2]);
        @(posedge clk);
        #1;
        start_read = 1'b1; raddr_reg = a; r_size_data = sz;
        if (expect_data)
            for (int i = 0; i < nw; i++) exp_q.push_back(data_of({a[31:2], 2'b00} + 32'(i * 4)));
        @(posedge clk);
        #1;
        start_read = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, output int dcyc);
        int n;
        n = 0;
        dcyc = -1;
        while (n < max_cyc) begin
            @(negedge clk);
            n++;
            if (read_done) begin
                dcyc = cyc;
                break;
            end
        end
    endtask

    task automatic wait_pushes(input int want, input int max_cyc);
        int n;
        int seen;
        n = 0;
        seen = 0;
        while (n < max_cyc && seen < want) begin
            @(negedge clk);
            n++;
            if (fifo_wen) seen++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start_read = 1'b0; fifo_full = 1'b0;
        raddr_reg = '0; r_size_data = '0;
        repeat (2) @(negedge clk);
        total++;
        if ({arvalid, rready, fifo_wen, read_done, rd_err} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctrl: arvalid,rready,wen,done,err=%b required 00000",
                     {arvalid, rready, fifo_wen, read_done, rd_err});
        end
        total++;
        if (araddr !== 32'h0 || arlen !== 8'h0 || fifo_wdata !== rdata) begin
            bad++;
            $display("FAIL reset_data: araddr=%h arlen=%0d wdata=%h required 0 0 %h",
                     araddr, arlen, fifo_wdata, rdata);
        end
        total++;
        if (arid !== 4'd0 || arsize !== 3'b010 || arburst !== 2'b01) begin
            bad++;
            $display("FAIL ar_consts: arid=%0d arsize=%b arburst=%b required 0 010 01",
                     arid, arsize, arburst);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single;
        int d;
        clear_sb();
        exp_ar.push_back({32'h100, 8'd15});
        issue(32'h0000_0100, 16'd64, 1'b1);
        wait_done(200, d);
        total++;
        if (d < 0) begin bad++; $display("FAIL single_done: no read_done required pulse"); end
        total++;
        if (push_cnt != 16 || last_push_cyc - first_push_cyc != 15) begin
            bad++;
            $display("FAIL single_pushes: got %0d over %0d cycles required 16 over 15",
                     push_cnt, last_push_cyc - first_push_cyc);
        end
        total++;
        if (d != last_push_cyc + 2) begin
            bad++;
            $display("FAIL single_done_time: got cycle %0d required %0d", d, last_push_cyc + 2);
        end
        total++;
        if (rd_err !== 1'b0 || exp_q.size() != 0 || exp_ar.size() != 0) begin
            bad++;
            $display("FAIL single_end: rd_err=%b left=%0d ar_left=%0d required 0 0 0",
                     rd_err, exp_q.size(), exp_ar.size());
        end
        @(negedge clk);
        total++;
        if (read_done !== 1'b0 || done_cnt != 1) begin
            bad++;
            $display("FAIL single_pulse: read_done=%b count=%0d required 0 1", read_done, done_cnt);
        end
    endtask

    task automatic test_multi;
        int d;
        clear_sb();
        exp_ar.push_back({32'h100, 8'd15});
        exp_ar.push_back({32'h140, 8'd1});
        issue(32'h0000_0100, 16'd72, 1'b1);
        wait_done(300, d);
        @(negedge clk);
        total++;
        if (d < 0 || push_cnt != 18 || done_cnt != 1) begin
            bad++;
            $display("FAIL multi: done_cyc=%0d pushes=%0d dones=%0d required >=0 18 1", d, push_cnt, done_cnt);
        end
        total++;
        if (exp_q.size() != 0 || exp_ar.size() != 0 || rd_err !== 1'b0) begin
            bad++;
            $display("FAIL multi_end: left=%0d ar_left=%0d rd_err=%b required 0 0 0",
                     exp_q.size(), exp_ar.size(), rd_err);
        end
    endtask

    task automatic test_4k_split;
        int d;
        clear_sb();
        exp_ar.push_back({32'hFF8, 8'd1});
        exp_ar.push_back({32'h1000, 8'd5});
        issue(32'h0000_0FF8, 16'd32, 1'b1);
        wait_done(300, d);
        total++;
        if (d < 0 || push_cnt != 8 || exp_q.size() != 0 || exp_ar.size() != 0) begin
            bad++;
            $display("FAIL split_4k: done_cyc=%0d pushes=%0d left=%0d ar_left=%0d required >=0 8 0 0",
                     d, push_cnt, exp_q.size(), exp_ar.size());
        end
    endtask

    task automatic test_backpressure;
        int d;
        int hold_bad;
        clear_sb();
        exp_ar.push_back({32'h2000, 8'd15});
        issue(32'h0000_2000, 16'd64, 1'b1);
        wait_pushes(2, 100);
        @(posedge clk);
        #1;
        fifo_full = 1'b1;
        hold_bad = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++;
            if (rready !== 1'b0 || fifo_wen !== 1'b0) begin
                bad++;
                $display("FAIL full_hold: cycle %0d rready=%b fifo_wen=%b required 0 0", k, rready, fifo_wen);
            end
        end
        total++;
        if (push_cnt != 2) begin
            bad++;
            $display("FAIL full_count: pushes before release %0d required 2", push_cnt);
        end
        @(posedge clk);
        #1;
        fifo_full = 1'b0;
        wait_done(300, d);
        total++;
        if (d < 0 || push_cnt != 16 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL full_end: done_cyc=%0d pushes=%0d left=%0d required >=0 16 0", d, push_cnt, exp_q.size());
        end
    endtask

    task automatic test_ar_delay;
        int d;
        int waits;
        int n;
        clear_sb();
        ar_delay = 5;
        exp_ar.push_back({32'h200, 8'd3});
        issue(32'h0000_0200, 16'd16, 1'b1);
        waits = 0;
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            n++;
            if (arvalid && arready) break;
            if (arvalid) begin
                waits++;
                total++;
                if (araddr !== 32'h200 || arlen !== 8'd3) begin
                    bad++;
                    $display("FAIL ar_hold: araddr=%h arlen=%0d required 200 3", araddr, arlen);
                end
            end
        end
        total++;
        if (waits != 5) begin
            bad++;
            $display("FAIL ar_wait: got %0d stalled cycles required 5", waits);
        end
        wait_done(200, d);
        ar_delay = 0;
        total++;
        if (d < 0 || push_cnt != 4 || exp_ar.size() != 0) begin
            bad++;
            $display("FAIL ar_delay_end: done_cyc=%0d pushes=%0d ar_left=%0d required >=0 4 0", d, push_cnt, exp_ar.size());
        end
    endtask

    task automatic test_zero_and_ignore;
        int d;
        int extra_ar;
        clear_sb();
        @(posedge clk);
        #1;
        start_read = 1'b1; raddr_reg = 32'h500; r_size_data = 16'd3;
        @(negedge clk);
        total++;
        if (arvalid !== 1'b0 || read_done !== 1'b0) begin
            bad++;
            $display("FAIL zero_k0: arvalid=%b read_done=%b required 0 0", arvalid, read_done);
        end
        @(posedge clk);
        #1;
        start_read = 1'b0;
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            total++;
            if (arvalid !== 1'b0 || read_done !== (k == 2)) begin
                bad++;
                $display("FAIL zero_k%0d: arvalid=%b read_done=%b required 0 %b", k, arvalid, read_done, (k == 2));
            end
        end
        clear_sb();
        exp_ar.push_back({32'h600, 8'd15});
        issue(32'h0000_0600, 16'd64, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        start_read = 1'b1; raddr_reg = 32'h800; r_size_data = 16'd16;
        @(posedge clk);
        #1;
        start_read = 1'b0;
        wait_done(300, d);
        extra_ar = 0;
        repeat (5) begin
            @(negedge clk);
            if (arvalid) extra_ar++;
        end
        total++;
        if (d < 0 || push_cnt != 16 || done_cnt != 1 || extra_ar != 0 || exp_ar.size() != 0) begin
            bad++;
            $display("FAIL ignore_start: done_cyc=%0d pushes=%0d dones=%0d extra_ar=%0d required >=0 16 1 0",
                     d, push_cnt, done_cnt, extra_ar);
        end
    endtask

    task automatic test_slverr;
        int d;
        clear_sb();
        glob_beat = 0;
        err_beat = 1;
        exp_ar.push_back({32'h400, 8'd3});
        issue(32'h0000_0400, 16'd16, 1'b1);
        wait_done(200, d);
        total++;
        if (d < 0 || push_cnt != 4 || rd_err !== 1'b1) begin
            bad++;
            $display("FAIL slverr: done_cyc=%0d pushes=%0d rd_err=%b required >=0 4 1", d, push_cnt, rd_err);
        end
        repeat (3) @(negedge clk);
        total++;
        if (rd_err !== 1'b1) begin
            bad++;
            $display("FAIL slverr_sticky: rd_err=%b required 1", rd_err);
        end
        err_beat = -1;
        clear_sb();
        exp_ar.push_back({32'h440, 8'd3});
        issue(32'h0000_0440, 16'd16, 1'b1);
        @(negedge clk);
        total++;
        if (rd_err !== 1'b0) begin
            bad++;
            $display("FAIL slverr_clear: rd_err=%b required 0", rd_err);
        end
        wait_done(200, d);
        total++;
        if (d < 0 || push_cnt != 4 || rd_err !== 1'b0) begin
            bad++;
            $display("FAIL slverr_next: done_cyc=%0d pushes=%0d rd_err=%b required >=0 4 0", d, push_cnt, rd_err);
        end
    endtask

    task automatic test_reset_mid;
        int d;
        clear_sb();
        glob_beat = 0;
        err_beat = 0;
        exp_ar.push_back({32'h3000, 8'd15});
        issue(32'h0000_3000, 16'd64, 1'b1);
        wait_pushes(5, 100);
        total++;
        if (rd_err !== 1'b1) begin
            bad++;
            $display("FAIL mid_err_before: rd_err=%b required 1", rd_err);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        err_beat = -1;
        exp_q.delete();
        exp_ar.delete();
        @(negedge clk);
        total++;
        if ({arvalid, rready, fifo_wen, read_done, rd_err} !== 5'b0 ||
            araddr !== 32'h0 || arlen !== 8'h0 || fifo_wdata !== rdata) begin
            bad++;
            $display("FAIL mid_reset: ctrl=%b araddr=%h arlen=%0d required 00000 0 0",
                     {arvalid, rready, fifo_wen, read_done, rd_err}, araddr, arlen);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_sb();
        exp_ar.push_back({32'h3100, 8'd3});
        issue(32'h0000_3100, 16'd16, 1'b1);
        wait_done(200, d);
        total++;
        if (d < 0 || push_cnt != 4 || rd_err !== 1'b0 || exp_q.size() != 0 || exp_ar.size() != 0) begin
            bad++;
            $display("FAIL mid_after: done_cyc=%0d pushes=%0d rd_err=%b left=%0d required >=0 4 0 0",
                     d, push_cnt, rd_err, exp_q.size());
        end
    endtask

    initial begin
        clear_sb();
        test_reset();
        test_single();
        test_multi();
        test_4k_split();
        test_backpressure();
        test_ar_delay();
        test_zero_and_ignore();
        test_slverr();
        test_reset_mid();
        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dma_read_engine.md
# dma_read_engine

AXI4 read-side engine of the DMA. Accepts a one-cycle `start_read` command with source address and byte count from the DMA controller, issues INCR read bursts on an AXI4 read channel, and pushes every returned word into the transfer FIFO that feeds the write engine. Pulses `read_done` once the last beat has been pushed.

## Interface
- `ADDR_W`, 32, AXI address width
- `MAX_BURST`, 16, maximum beats per burst (1..16)
- `AXI_ID`, 0, constant value driven on `arid`
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `start_read`  in  1  one-cycle command pulse from controller
- `r_size_data`  in  16  transfer size in bytes; bits [1:0] ignored
- `raddr_reg`  in  32  source byte address; bits [1:0] forced to 0
- `read_done`  out  1  one-cycle completion pulse
- `rd_err`  out  1  sticky error flag; cleared on the next accepted `start_read`
- `arid`  out  4  constant `AXI_ID`
- `araddr`  out  ADDR_W  burst start address
- `arlen`  out  8  beats minus 1
- `arsize`  out  3  constant 3'b010 (4 bytes)
- `arburst`  out  2  constant 2'b01 (INCR)
- `arvalid`  out  1  address valid
- `arready`  in  1  address ready
- `rdata`  in  32  read data
- `rresp`  in  2  read response
- `rlast`  in  1  last beat of burst
- `rvalid`  in  1  data valid
- `rready`  out  1  data ready
- `fifo_wdata`  out  32  word pushed to transfer FIFO
- `fifo_wen`  out  1  push strobe
- `fifo_full`  in  1  transfer FIFO full

## Operation
- States: IDLE, ADDR, DATA, DONE.
- IDLE: on `start_read`, latch `addr = {raddr_reg[31:2],2'b00}` and `words = r_size_data[15:2]`, then clear `rd_err`. If `words == 0`, go to DONE. Otherwise go to ADDR.
- `start_read` in any state other than IDLE is ignored.
- Burst size: `beats = min(MAX_BURST, words_remaining, (4096 - addr[11:0]) >> 2)`. Bursts never cross a 4 KB boundary. `arlen = beats - 1`, registered on entry to ADDR.
- ADDR: `arvalid` = 1. `araddr` and `arlen` stay stable until `arvalid && arready`. On that handshake: go to DATA, `addr += beats*4`, `beat_cnt = beats`.
- DATA: `rready = !fifo_full`. The FIFO push is combinational: `fifo_wen = rvalid && rready`, `fifo_wdata = rdata`.
- On each push: `beat_cnt--` and `words_remaining--`.
- The burst ends when the push of the beat with `beat_cnt == 1` completes. Then go to ADDR if `words_remaining > 0`, else go to DONE.
- DONE: `read_done` = 1 for exactly one cycle, then go to IDLE.
- Errors: `rd_err` is set by either of these, and the transfer still completes with all beats pushed:
  - `rresp != 2'b00` on any accepted beat;
  - `rlast` inconsistent with `beat_cnt` (asserted early, or absent on the final beat).
- `rid` is not checked. There is one outstanding burst at a time.
- Reset mid-operation returns the block to IDLE immediately and clears all counters. Any in-flight AXI burst is abandoned. The system resets the slave together with this block.

## Timing
- Reset values: `arvalid`=0, `rready`=0, `fifo_wen`=0, `read_done`=0, `rd_err`=0, `araddr`=0, `arlen`=0, `fifo_wdata`=`rdata` (pass-through).
- `start_read` in cycle N gives `arvalid` high in N+1.
- If `words == 0`, `read_done` is high in N+2.
- AR handshake in cycle M: `rready` can be high from M+1.
- Final push in cycle K: next `arvalid` in K+1, or `read_done` in K+2 (DONE state in K+1 registers the pulse).
- `rready` and `fifo_wen` are never high outside DATA.
- `fifo_wen` is never high while `fifo_full` = 1.
- Throughput: 1 word per cycle inside a burst when `rvalid` = 1 and the FIFO is not full. Between bursts there is a 1-cycle gap plus AR latency.
- Address arithmetic is 32-bit unsigned and wraps modulo 2^32; no range checking (the controller validates ranges).

## Test plan
- 64 bytes from 0x0000_0100, slave always ready:
  - one AR with `araddr`=0x100, `arlen`=15;
  - 16 pushes in consecutive cycles with data in order;
  - `read_done` 1 cycle after the DATA→DONE transition; `rd_err`=0.
- 72 bytes from 0x100: AR (0x100, arlen 15) then AR (0x140, arlen 1); 18 pushes total; one `read_done`.
- 4 KB split, 32 bytes from 0x0000_0FF8: AR (0xFF8, arlen 1) then AR (0x1000, arlen 5); 8 pushes.
- Backpressure:
  - `fifo_full` held for beats 3–6 of a 16-beat burst: `rready`=0 and no push during the hold; no word lost or duplicated; 16 pushes total.
  - `arready` delayed 5 cycles: `araddr`/`arlen` stable throughout.
- `r_size_data`=3 (rounds to 0 words): no `arvalid`; `read_done` pulse 2 cycles after `start_read`. Also check that a second `start_read` during a transfer is ignored.
- SLVERR on beat 2 of 4: all 4 beats pushed, `rd_err`=1 until the next `start_read`.
- Reset asserted mid-burst: all outputs return to reset values; a following 16-byte transfer completes normally.
